// File: rtl/bcd_display_engine_if.sv
// Value/handshake bundle between the arithmetic stage and the BCD display engine.
interface bcd_display_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_value;
    logic                  signed_mode;
    logic                  blank_lz;
    logic [7*DIGITS-1:0]   seg_out;
    logic                  neg;
    logic                  overflow;
    logic                  out_valid;

    modport master (
        output in_valid, in_value, signed_mode, blank_lz,
        input  in_ready, seg_out, neg, overflow, out_valid
    );

    modport slave (
        input  in_valid, in_value, signed_mode, blank_lz,
        output in_ready, seg_out, neg, overflow, out_valid
    );
endinterface

// File: rtl/bcd_display_engine.sv
// Binary value -> BCD (sequential double-dabble, one bit per clock) -> registered 7-segment digits,
// with optional two's-complement input, leading-zero blanking and overflow dashes.
module bcd_display_engine #(
    parameter int WIDTH          = 16,
    parameter int DIGITS         = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_display_engine_if.slave  bus
);
    localparam int BCD_INT = (3*WIDTH+9)/10 + 1;
    localparam int BCD_W   = 4*BCD_INT;
    localparam int EXT     = (DIGITS > BCD_INT) ? DIGITS : BCD_INT;
    localparam int CNT_W   = $clog2(WIDTH+1);
    localparam int SR_W    = BCD_W + WIDTH;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH-1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return (SEG_ACTIVE_LOW != 0) ? s : ~s;
    endfunction

    state_t                  r_state, w_state_next;
    logic                    r_in_ready, r_out_valid, r_neg, r_ovf;
    logic [7*DIGITS-1:0]     r_seg;
    logic [SR_W-1:0]         r_sr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_neg_pend, r_blank;

    logic                    w_accept, w_sign, w_ovf, w_seen;
    logic signed [WIDTH-1:0] w_sval;
    logic [WIDTH-1:0]        w_mag_in;
    logic [SR_W-1:0]         w_sr_adj;
    logic [4*EXT-1:0]        w_bcd_ext;
    logic [3:0]              w_digit;
    logic [7*DIGITS-1:0]     w_seg;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_sval   = $signed(bus.in_value);
    assign w_sign   = bus.signed_mode & bus.in_value[WIDTH-1];
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_mag_in = w_sign ? $unsigned(-w_sval) : bus.in_value;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_CONVERT;
            S_CONVERT: if (r_cnt == LAST_IT) w_state_next = S_UPDATE;
            S_UPDATE:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // {bcd, mag} lives in one shift register so the whole word shifts as a unit.
    always_comb begin
        w_sr_adj = r_sr;
        for (int i = 0; i < BCD_INT; i++)
            w_sr_adj[WIDTH+4*i +: 4] = add3(r_sr[WIDTH+4*i +: 4]);
    end

    always_comb begin
        w_bcd_ext = '0;
        w_bcd_ext[BCD_W-1:0] = r_sr[SR_W-1:WIDTH];
        w_ovf = 1'b0;
        for (int k = DIGITS; k < EXT; k++)
            w_ovf = w_ovf | (w_bcd_ext[4*k +: 4] != 4'd0);
        w_seen  = 1'b0;
        w_digit = 4'd0;
        w_seg   = '0;
        for (int k = DIGITS-1; k >= 0; k--) begin
            w_digit = w_bcd_ext[4*k +: 4];
            if (w_ovf)
                w_seg[7*k +: 7] = seg_pol(SEG_DASH);
            else if (r_blank && !w_seen && (w_digit == 4'd0) && (k != 0))
                w_seg[7*k +: 7] = seg_pol(SEG_BLANK);
            else
                w_seg[7*k +: 7] = seg_pol(seg_code(w_digit));
            if (w_digit != 4'd0) w_seen = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_seg       <= {DIGITS{seg_pol(SEG_BLANK)}};
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (r_state == S_UPDATE);
            if (r_state == S_UPDATE) begin
                r_seg <= w_seg;
                r_neg <= r_neg_pend;
                r_ovf <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sr       <= {{BCD_W{1'b0}}, w_mag_in};
            r_cnt      <= '0;
            r_neg_pend <= w_sign & (bus.in_value != '0);
            r_blank    <= bus.blank_lz;
        end else if (r_state == S_CONVERT) begin
            r_sr  <= w_sr_adj << 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.seg_out   = r_seg;
    assign bus.neg       = r_neg;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_bcd_display_engine.sv
// Directed bench for bcd_display_engine at WIDTH=16, DIGITS=4, active-low segments.
module tb_bcd_display_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    bcd_display_engine_if #(.WIDTH(16), .DIGITS(4)) bus ();

    bcd_display_engine #(.WIDTH(16), .DIGITS(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one value, returns cycles from accept edge to out_valid (100 = timed out).
    task automatic convert(input logic [15:0] v, input logic sm, input logic bl, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.in_valid = 1'b1; bus.in_value = v; bus.signed_mode = sm; bus.blank_lz = bl;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.neg !== 1'b0 || bus.overflow !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", bus.neg, bus.overflow); else n_pass++;
        n_total++; if (bus.seg_out !== 28'hFFFFFFF) $display("FAIL rst_seg got=%h exp=%h", bus.seg_out, 28'hFFFFFFF); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        logic [27:0] exp;
        convert(16'd1234, 1'b0, 1'b0, lat);
        exp = {7'h79, 7'h24, 7'h30, 7'h19};
        n_total++; if (lat !== 17) $display("FAIL basic_latency got=%0d exp=17", lat); else n_pass++;
        n_total++; if (bus.seg_out !== exp) $display("FAIL basic_seg got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        n_total++; if (bus.neg !== 1'b0 || bus.overflow !== 1'b0) $display("FAIL basic_flags got=%b%b exp=00", bus.neg, bus.overflow); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_at_update got=%b exp=1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_pulse_width got=%b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.seg_out !== exp) $display("FAIL basic_hold got=%h exp=%h", bus.seg_out, exp); else n_pass++;
    endtask

    task automatic test_blanking();
        int lat;
        logic [27:0] exp;
        convert(16'd7, 1'b0, 1'b1, lat);
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h78};
        n_total++; if (bus.seg_out !== exp) $display("FAIL blank_7 got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        convert(16'd0, 1'b0, 1'b1, lat);
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        n_total++; if (bus.seg_out !== exp) $display("FAIL blank_0 got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        convert(16'd105, 1'b0, 1'b1, lat);
        exp = {7'h7F, 7'h79, 7'h40, 7'h12};
        n_total++; if (bus.seg_out !== exp) $display("FAIL blank_inner_zero got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        convert(16'd0, 1'b0, 1'b0, lat);
        exp = {7'h40, 7'h40, 7'h40, 7'h40};
        n_total++; if (bus.seg_out !== exp) $display("FAIL noblank_0 got=%h exp=%h", bus.seg_out, exp); else n_pass++;
    endtask

    task automatic test_overflow();
        int lat;
        logic [27:0] exp;
        convert(16'd9999, 1'b0, 1'b0, lat);
        exp = {7'h10, 7'h10, 7'h10, 7'h10};
        n_total++; if (bus.seg_out !== exp) $display("FAIL ovf_9999_seg got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_9999_flag got=%b exp=0", bus.overflow); else n_pass++;
        convert(16'd10000, 1'b0, 1'b0, lat);
        exp = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        n_total++; if (bus.seg_out !== exp) $display("FAIL ovf_10000_seg got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_10000_flag got=%b exp=1", bus.overflow); else n_pass++;
        convert(16'd65535, 1'b0, 1'b1, lat);
        n_total++; if (bus.overflow !== 1'b1 || bus.seg_out !== exp) $display("FAIL ovf_65535 got=%b/%h exp=1/%h", bus.overflow, bus.seg_out, exp); else n_pass++;
    endtask

    task automatic test_signed();
        int lat;
        logic [27:0] exp;
        convert(16'hFFFB, 1'b1, 1'b0, lat);
        exp = {7'h40, 7'h40, 7'h40, 7'h12};
        n_total++; if (bus.seg_out !== exp) $display("FAIL signed_m5_seg got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        n_total++; if (bus.neg !== 1'b1 || bus.overflow !== 1'b0) $display("FAIL signed_m5_flags got=%b%b exp=10", bus.neg, bus.overflow); else n_pass++;
        convert(16'h8000, 1'b1, 1'b0, lat);
        exp = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        n_total++; if (bus.neg !== 1'b1 || bus.overflow !== 1'b1) $display("FAIL signed_min_flags got=%b%b exp=11", bus.neg, bus.overflow); else n_pass++;
        n_total++; if (bus.seg_out !== exp) $display("FAIL signed_min_seg got=%h exp=%h", bus.seg_out, exp); else n_pass++;
        convert(16'hFFFB, 1'b0, 1'b0, lat);
        n_total++; if (bus.neg !== 1'b0 || bus.overflow !== 1'b1) $display("FAIL unsigned_fffb_flags got=%b%b exp=01", bus.neg, bus.overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int guard = 0;
        int stray = 0;
        logic [27:0] exp;
        while (!bus.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.in_valid = 1'b1; bus.in_value = 16'd4321; bus.signed_mode = 1'b0; bus.blank_lz = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.seg_out !== 28'hFFFFFFF) $display("FAIL midrst_seg got=%h exp=%h", bus.seg_out, 28'hFFFFFFF); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL midrst_ctrl got=%b%b exp=00", bus.in_ready, bus.out_valid); else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray++;
        end
        n_total++; if (stray !== 0) $display("FAIL midrst_no_output got=%0d exp=0", stray); else n_pass++;
        convert(16'd42, 1'b0, 1'b0, lat);
        exp = {7'h40, 7'h40, 7'h19, 7'h24};
        n_total++; if (lat !== 17) $display("FAIL midrst_latency got=%0d exp=17", lat); else n_pass++;
        n_total++; if (bus.seg_out !== exp) $display("FAIL midrst_seg_after got=%h exp=%h", bus.seg_out, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        int cyc = 0;
        int acc_cnt = 0;
        int ov_cnt = 0;
        int busy_ready = 0;
        int acc_t[2];
        int ov_t[2];
        logic [27:0] res[2];
        logic accepted;
        acc_t = '{0, 0}; ov_t = '{0, 0}; res = '{28'h0, 28'h0};
        while (!bus.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.in_valid = 1'b1; bus.in_value = 16'd1; bus.signed_mode = 1'b0; bus.blank_lz = 1'b0;
        while (cyc < 80 && ov_cnt < 2) begin
            accepted = bus.in_valid & bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (accepted && acc_cnt < 2) begin
                acc_t[acc_cnt] = cyc;
                acc_cnt++;
                if (acc_cnt == 1) bus.in_value = 16'd2;
                else begin bus.in_valid = 1'b0; bus.in_value = 16'd5; end
            end
            if (bus.out_valid) begin
                res[ov_cnt] = bus.seg_out;
                ov_t[ov_cnt] = cyc;
                ov_cnt++;
            end else if (acc_cnt > ov_cnt && bus.in_ready) begin
                busy_ready++;
            end
        end
        bus.in_valid = 1'b0;
        n_total++; if (acc_cnt !== 2 || ov_cnt !== 2) $display("FAIL b2b_counts got=%0d/%0d exp=2/2", acc_cnt, ov_cnt); else n_pass++;
        n_total++; if (acc_t[1] - acc_t[0] !== 18) $display("FAIL b2b_spacing got=%0d exp=18", acc_t[1] - acc_t[0]); else n_pass++;
        n_total++; if (ov_t[0] - acc_t[0] !== 17) $display("FAIL b2b_latency got=%0d exp=17", ov_t[0] - acc_t[0]); else n_pass++;
        n_total++; if (busy_ready !== 0) $display("FAIL b2b_ready_busy got=%0d exp=0", busy_ready); else n_pass++;
        n_total++; if (res[0] !== {7'h40, 7'h40, 7'h40, 7'h79}) $display("FAIL b2b_first got=%h exp=%h", res[0], {7'h40, 7'h40, 7'h40, 7'h79}); else n_pass++;
        n_total++; if (res[1] !== {7'h40, 7'h40, 7'h40, 7'h24}) $display("FAIL b2b_second got=%h exp=%h", res[1], {7'h40, 7'h40, 7'h40, 7'h24}); else n_pass++;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_value    = '0;
        bus.signed_mode = 1'b0;
        bus.blank_lz    = 1'b0;
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_signed();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bcd_display_engine.md
Name: bcd_display_engine

Overview:
- Parametrised successor to the fixed 12-bit add / binary-to-BCD / 7-segment chain.
- Accepts a WIDTH-bit binary value over a valid/ready handshake.
- Converts the value to BCD with a sequential double-dabble engine (one bit per cycle).
- Drives DIGITS registered 7-segment patterns, with optional signed mode, leading-zero blanking and overflow indication.
- Sits between the arithmetic stage and the display pins of the top level.

Parameters:
- WIDTH, 16, input value width in bits (4..32).
- DIGITS, 4, number of displayed 7-segment digits (1..8).
- SEG_ACTIVE_LOW, 1, 1 = segment lit by 0 (common anode); 0 = inverted polarity.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on clk.
- in_valid  input  1  in_value / signed_mode / blank_lz are valid.
- in_ready  output  1  engine idle, can accept a value.
- in_value  input  WIDTH  binary value to display.
- signed_mode  input  1  1 = in_value is two's complement; sampled at accept.
- blank_lz  input  1  1 = blank leading zeros; sampled at accept.
- seg_out  output  7*DIGITS  digit k at bits [7k+6:7k], k=0 units; bit order {g,f,e,d,c,b,a}.
- neg  output  1  displayed value is negative.
- overflow  output  1  magnitude exceeds 10^DIGITS - 1.
- out_valid  output  1  one-cycle pulse when seg_out/neg/overflow update.

Behaviour:
- Reset (rst=0 at an edge):
  - state = IDLE; in_ready = 0; out_valid = 0; neg = 0; overflow = 0.
  - Every digit of seg_out shows blank.
  - Any conversion in progress is abandoned; outputs do not update for it.
- in_ready is registered:
  - 1 from the first edge after rst returns high, while state = IDLE.
  - Drops to 0 on the accept edge.
- Accept: in_valid & in_ready at edge T.
  - Capture mag = (signed_mode & in_value[WIDTH-1]) ? -in_value : in_value, as a WIDTH-bit unsigned value. -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
  - Capture the sign, blank_lz and signed_mode.
  - Clear the internal BCD register: BCD_INT = (3*WIDTH+9)/10 + 1 digits.
  - Go to CONVERT.
- CONVERT, edges T+1 .. T+WIDTH, one iteration per edge:
  - Each BCD digit >= 5 gets +3.
  - Then {bcd, mag} shifts left 1.
  - A bit counter of width clog2(WIDTH+1) ends the state after exactly WIDTH iterations.
- UPDATE, edge T+WIDTH+1:
  - overflow = any internal digit at index >= DIGITS is nonzero.
  - neg = captured sign & (mag != 0).
  - seg_out loaded; out_valid = 1 for this one cycle; in_ready = 1; return to IDLE.
  - Total latency: accept edge to visible output = WIDTH+1 cycles; throughput one value per WIDTH+2 cycles.
- Segment codes, active-low form, {g..a}:
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
  - blank=7Fh, dash=3Fh.
  - SEG_ACTIVE_LOW=0 inverts every bit.
- Overflow: every digit shows dash; neg still reflects the sign.
- Blanking: with blank_lz=1, each zero digit above the highest nonzero digit is blank. Digit 0 is never blanked (value 0 shows "0").
- in_valid while busy is ignored (no accept); the source must hold it. in_value changes during CONVERT have no effect.
- in_valid held high continuously: a new accept occurs on the first edge in IDLE, i.e. the edge after UPDATE.
- Outputs hold their last values between updates.

Test Plan:
- WIDTH=16, DIGITS=4: reset, then accept 1234 unsigned, blank_lz=0 -> out_valid pulse exactly 17 cycles after accept; seg_out = {79h,24h,30h,19h} (thousands..units); neg=0, overflow=0.
- Accept 7, blank_lz=1 -> digits 3..1 = 7Fh, digit 0 = 78h. Accept 0, blank_lz=1 -> {7Fh,7Fh,7Fh,40h}.
- Accept 9999 -> all 10h, overflow=0. Accept 10000 -> all 3Fh, overflow=1. Accept 65535 -> overflow=1.
- signed_mode=1: in_value=FFFBh (-5) -> neg=1, units = 12h. in_value=8000h -> magnitude 32768, overflow=1, neg=1.
- Reset mid-operation: pull rst low 5 cycles into CONVERT -> next edge seg_out all 7Fh, no out_valid; new accept after release -> correct result with 17-cycle latency.
- Back-to-back: hold in_valid=1 with values 1, then 2 -> accepts 18 cycles apart; in_ready=0 throughout each CONVERT; values presented while busy are never captured.
